regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//  Integer register file and hazard scoreboard. It is the consumer of the write-back port and supplies operands to decode.
//  It has 31 writable XLEN registers (x0 reads as zero), 2 combinational read ports, and 1 write port fed by write_back.
//  Per-register pending-write counters track in-flight writers and raise a decode stall on RAW hazards.
// PARAMETERS
//  XLEN   64  register data width
//  CNT_W  2   width of each per-register pending-write counter (max in flight per rd = 2**CNT_W-1)
// PORTS
//  clk                     in   1     core clock, rising edge
//  rst                     in   1     asynchronous, active-high reset
//  regfile_i_wb_rd         in   5     write-back destination (from write_back_o_rd)
//  regfile_i_wb_data       in   XLEN  write-back data (from write_back_o_data)
//  regfile_i_wb_wen        in   1     write-back enable (from write_back_o_reg_wen)
//  regfile_i_rs1           in   5     decode source register 1 index
//  regfile_i_rs2           in   5     decode source register 2 index
//  regfile_i_issue_valid   in   1     decode hands an instruction to execute this cycle
//  regfile_i_issue_rd      in   5     destination of the issuing instruction
//  regfile_i_issue_wen     in   1     issuing instruction writes rd
//  regfile_i_flush         in   1     pipeline flush (branch mispredict / trap)
//  regfile_o_rs1_data      out  XLEN  operand 1
//  regfile_o_rs2_data      out  XLEN  operand 2
//  regfile_o_stall         out  1     RAW hazard or counter-full; decode must hold
// BEHAVIOUR
//  - Reset (async, rst=1): all registers = 0 and all pending counters = 0, so rs*_data = 0 and stall = 0 immediately.
//  - Write: on posedge clk, if wb_wen && wb_rd!=0 then reg[wb_rd] <= wb_data. Writes to x0 are dropped.
//  - Read: rsN_data is combinational. Index 0 -> 0, otherwise reg[rsN] (bypass rules under CONFIGURATION).
//  - Counter update each posedge, evaluated per register r!=0:
//      inc = issue_valid && !stall && issue_wen && issue_rd==r && !flush
//      dec = wb_wen && wb_rd==r && cnt[r]!=0
//      inc&dec -> unchanged; inc -> +1; dec -> -1. Never decrements below 0 (a late write after a flush is harmless).
//  - Flush: all counters <= 0 at the clock edge. A write-back occurring in the same cycle still commits its data.
//    An issue asserted in a flush cycle is not counted.
//  - Stall (combinational):
//      stall = haz(rs1) | haz(rs2) | full
//      full = issue_wen && cnt[issue_rd]==2**CNT_W-1 && issue_rd!=0
//      haz(s) = s!=0 && cnt[s]!=0 && !resolved(s)
//  - An issue with stall=1 is ignored by the scoreboard. Decode re-presents the instruction next cycle.
//  - x0: never counted, never hazards, never stalls.
//  - Latency: write-back data becomes visible in the same cycle (bypass enabled) or the next cycle (bypass disabled).
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//   - If wb_wen && wb_rd==rsN && rsN!=0, then rsN_data = wb_data (write-first).
//   - resolved(s) = wb_wen && wb_rd==s && cnt[s]==1, so the final pending write releases the stall in its own cycle.
//  REGFILE_BYPASS_EN undefined:
//   - Read returns the pre-edge reg[rsN].
//   - resolved(s) = 0, so the stall releases one cycle after the final write-back.
// TESTING
//  1 Reset: assert rst mid-run with cnt[5]=1 and reg[5]=0xAA -> rs1_data=0 and stall=0 while rst is high, and after release.
//  2 Write/read: wb x7<=0x1234_5678_9ABC_DEF0, then rs1=7 on the next cycle -> rs1_data=0x123456789ABCDEF0. A wb to x0 of 0xFF -> rs2=0 reads 0.
//  3 RAW: issue rd=3, then rs2=3 -> stall=1 until wb x3=0x55. With bypass: stall=0 and rs2_data=0x55 in the wb cycle.
//     Without bypass: stall=0 one cycle later.
//  4 Multi-writer: issue rd=9 twice, then the first wb x9 -> stall stays 1 (cnt=1); the second wb -> released.
//    Issue rd=9 and wb x9 in the same cycle -> cnt unchanged.
//  5 Full: 3 accepted issues to rd=4 (CNT_W=2), a 4th issue -> stall=1 and cnt stays 3.
//  6 Flush: cnt[10]=2, flush=1 together with issue rd=10 -> all cnt=0 and stall=0.
//    A later wb x10=0x77 -> reg updated, cnt stays 0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Integer register file (x0 hardwired to zero) with per-register pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN: write-first read bypass and same-cycle hazard release.
module regfile_scoreboard #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      regfile_i_wb_rd,
  input  logic [XLEN-1:0] regfile_i_wb_data,
  input  logic            regfile_i_wb_wen,
  input  logic [4:0]      regfile_i_rs1,
  input  logic [4:0]      regfile_i_rs2,
  input  logic            regfile_i_issue_valid,
  input  logic [4:0]      regfile_i_issue_rd,
  input  logic            regfile_i_issue_wen,
  input  logic            regfile_i_flush,
  output logic [XLEN-1:0] regfile_o_rs1_data,
  output logic [XLEN-1:0] regfile_o_rs2_data,
  output logic            regfile_o_stall
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [XLEN-1:0]  regs [32];
  logic [CNT_W-1:0] cnt  [32];

  logic        haz1, haz2, full, accept;
  logic [31:0] inc_vec, dec_vec;

  // Operand read and hazard detection
  always_comb begin
    regfile_o_rs1_data = regs[regfile_i_rs1];
    regfile_o_rs2_data = regs[regfile_i_rs2];
    haz1 = (regfile_i_rs1 != 5'd0) && (cnt[regfile_i_rs1] != '0);
    haz2 = (regfile_i_rs2 != 5'd0) && (cnt[regfile_i_rs2] != '0);
`ifdef REGFILE_BYPASS_EN
    if (regfile_i_wb_wen && regfile_i_wb_rd == regfile_i_rs1) begin
      regfile_o_rs1_data = regfile_i_wb_data;
      if (cnt[regfile_i_rs1] == CNT_ONE) haz1 = 1'b0;
    end
    if (regfile_i_wb_wen && regfile_i_wb_rd == regfile_i_rs2) begin
      regfile_o_rs2_data = regfile_i_wb_data;
      if (cnt[regfile_i_rs2] == CNT_ONE) haz2 = 1'b0;
    end
`endif
    if (regfile_i_rs1 == 5'd0) regfile_o_rs1_data = '0;
    if (regfile_i_rs2 == 5'd0) regfile_o_rs2_data = '0;
    full = regfile_i_issue_wen && (regfile_i_issue_rd != 5'd0) &&
           (cnt[regfile_i_issue_rd] == CNT_MAX);
    regfile_o_stall = haz1 | haz2 | full;
  end

  // One-hot increment/decrement requests; inc and dec on the same register cancel
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    accept  = regfile_i_issue_valid && !regfile_o_stall && regfile_i_issue_wen &&
              !regfile_i_flush && (regfile_i_issue_rd != 5'd0);
    if (accept) inc_vec[regfile_i_issue_rd] = 1'b1;
    if (regfile_i_wb_wen && (regfile_i_wb_rd != 5'd0) && (cnt[regfile_i_wb_rd] != '0))
      dec_vec[regfile_i_wb_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < 32; r++) regs[r] <= '0;
    end else if (regfile_i_wb_wen && regfile_i_wb_rd != 5'd0) begin
      regs[regfile_i_wb_rd] <= regfile_i_wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < 32; r++) cnt[r] <= '0;
    end else if (regfile_i_flush) begin
      for (int unsigned r = 0; r < 32; r++) cnt[r] <= '0;
    end else begin
      for (int unsigned r = 1; r < 32; r++) begin
        if (inc_vec[r] && !dec_vec[r])
          cnt[r] <= cnt[r] + CNT_ONE;
        else if (dec_vec[r] && !inc_vec[r])
          cnt[r] <= cnt[r] - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: directed scenarios plus random traffic against a reference model.
module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [63:0] wb_data = '0;
  logic        wb_wen = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0;
  logic        iv = 1'b0;
  logic [4:0]  ird = '0;
  logic        iwen = 1'b0;
  logic        flush = 1'b0;
  logic [63:0] rs1_data, rs2_data;
  logic        stall;

  regfile_scoreboard #(.XLEN(64), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .regfile_i_wb_rd(wb_rd), .regfile_i_wb_data(wb_data), .regfile_i_wb_wen(wb_wen),
    .regfile_i_rs1(rs1), .regfile_i_rs2(rs2),
    .regfile_i_issue_valid(iv), .regfile_i_issue_rd(ird), .regfile_i_issue_wen(iwen),
    .regfile_i_flush(flush),
    .regfile_o_rs1_data(rs1_data), .regfile_o_rs2_data(rs2_data), .regfile_o_stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] m1, m2;
    logic        ms;
    bit          cc;
    logic [63:0] c1, c2;
    logic        cs;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // Reference model: architectural register values and in-flight writer counts
  logic [63:0] m_reg [32];
  int          m_cnt [32];

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = '0;
      m_cnt[i] = 0;
    end
  endfunction

  function automatic logic [63:0] m_read(input logic [4:0] s);
    if (s == 0) return '0;
    if (BYP && wb_wen && wb_rd == s) return wb_data;
    return m_reg[s];
  endfunction

  function automatic bit m_haz(input logic [4:0] s);
    if (s == 0 || m_cnt[s] == 0) return 1'b0;
    if (BYP && wb_wen && wb_rd == s && m_cnt[s] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_stall();
    bit full;
    full = iwen && ird != 0 && m_cnt[ird] == 3;
    return m_haz(rs1) || m_haz(rs2) || full;
  endfunction

  function automatic void model_update(input bit st);
    bit dec, inc;
    dec = wb_wen && wb_rd != 0 && m_cnt[wb_rd] > 0;
    inc = iv && !st && iwen && ird != 0 && !flush;
    if (wb_wen && wb_rd != 0) m_reg[wb_rd] = wb_data;
    if (flush) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    end else begin
      if (dec) m_cnt[wb_rd] = m_cnt[wb_rd] - 1;
      if (inc) m_cnt[ird] = m_cnt[ird] + 1;
    end
  endfunction

  task automatic tick(input string name, input bit cc,
                      input logic [63:0] c1, input logic [63:0] c2, input logic cs);
    exp_t e;
    if (rst) model_clear();
    e.name = name;
    e.m1 = m_read(rs1);
    e.m2 = m_read(rs2);
    e.ms = m_stall();
    e.cc = cc; e.c1 = c1; e.c2 = c2; e.cs = cs;
    q.push_back(e);
    @(posedge clk);
    if (!rst) model_update(e.ms);
    #1;
  endtask

  task automatic step(input string name);
    tick(name, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic idle();
    wb_wen = 0; wb_rd = 0; wb_data = '0; rs1 = 0; rs2 = 0;
    iv = 0; ird = 0; iwen = 0; flush = 0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [63:0] d);
    wb_wen = 1; wb_rd = r; wb_data = d;
  endtask

  task automatic issue(input logic [4:0] r);
    iv = 1; iwen = 1; ird = r;
  endtask

  task automatic cmp64(input string n, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", n, got, want);
    end
  endtask

  // Monitor: one expectation per cycle, compared on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp64({e.name, ".rs1"}, rs1_data, e.m1);
        cmp64({e.name, ".rs2"}, rs2_data, e.m2);
        cmp64({e.name, ".stall"}, {63'd0, stall}, {63'd0, e.ms});
        if (e.cc) begin
          cmp64({e.name, ".rs1_spec"}, rs1_data, e.c1);
          cmp64({e.name, ".rs2_spec"}, rs2_data, e.c2);
          cmp64({e.name, ".stall_spec"}, {63'd0, stall}, {63'd0, e.cs});
        end
      end
    end
  end

  initial begin
    model_clear();
    @(posedge clk); #1;
    rst = 1; idle();
    tick("reset", 1, '0, '0, 0);
    rst = 0;
    step("idle");

    // Write then read; write to x0 dropped
    wb(7, 64'h1234_5678_9ABC_DEF0); step("wb7");
    idle(); rs1 = 7; tick("rd7", 1, 64'h1234_5678_9ABC_DEF0, '0, 0);
    wb(0, 64'hFF); rs1 = 7; step("wb0");
    wb_wen = 0; rs2 = 0; tick("rd0", 1, 64'h1234_5678_9ABC_DEF0, '0, 0);

    // RAW on x3
    idle(); issue(3); tick("iss3", 1, '0, '0, 0);
    idle(); rs2 = 3; tick("raw_stall", 1, '0, '0, 1);
    wb(3, 64'h55); tick("raw_wb", 1, '0, BYP ? 64'h55 : 64'h0, !BYP);
    wb_wen = 0; tick("raw_release", 1, '0, 64'h55, 0);

    // Two writers to x9
    idle(); issue(9); step("iss9a");
    step("iss9b");
    idle(); rs1 = 9; tick("mw_stall", 1, '0, '0, 1);
    wb(9, 64'h1); tick("mw_wb1", 1, BYP ? 64'h1 : 64'h0, '0, 1);
    wb(9, 64'h2); tick("mw_wb2", 1, BYP ? 64'h2 : 64'h1, '0, !BYP);
    wb_wen = 0; tick("mw_free", 1, 64'h2, '0, 0);
    idle(); issue(9); step("iss9c");
    issue(9); wb(9, 64'h3); step("inc_dec");
    idle(); rs1 = 9; tick("inc_dec_chk", 1, 64'h3, '0, 1);
    idle(); wb(9, 64'h4); step("mw_clean");

    // Counter saturation on x4
    idle(); issue(4); tick("full1", 1, '0, '0, 0);
    tick("full2", 1, '0, '0, 0);
    tick("full3", 1, '0, '0, 0);
    tick("full4", 1, '0, '0, 1);
    idle(); rs1 = 4; tick("full_hold", 1, '0, '0, 1);
    idle(); wb(4, 64'h44); step("drain1"); step("drain2"); step("drain3");
    idle(); rs1 = 4; tick("full_drain", 1, 64'h44, '0, 0);

    // Flush with a concurrent issue
    idle(); issue(10); step("iss10a"); step("iss10b");
    flush = 1; tick("flush", 1, '0, '0, 0);
    idle(); rs1 = 10; tick("flush_chk", 1, '0, '0, 0);
    idle(); wb(10, 64'h77); step("late_wb");
    idle(); rs1 = 10; tick("late_wb_chk", 1, 64'h77, '0, 0);
    idle(); issue(10); step("iss10c");
    idle(); rs1 = 10; tick("flush_cnt", 1, 64'h77, '0, 1);
    idle(); wb(10, 64'h78); step("clean10");

    // Reset mid-run with a pending writer on x5
    idle(); wb(5, 64'hAA); step("wb5");
    idle(); issue(5); step("iss5");
    idle(); rs1 = 5; tick("pre_rst", 1, 64'hAA, '0, 1);
    rst = 1; tick("rst_hi", 1, '0, '0, 0);
    tick("rst_hi2", 1, '0, '0, 0);
    rst = 0; tick("rst_rel", 1, '0, '0, 0);

    // Random traffic on a small register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      rst     = ($urandom_range(0, 199) == 0);
      wb_wen  = ($urandom_range(0, 2) != 0);
      wb_rd   = 5'($urandom_range(0, 7));
      wb_data = {$urandom, $urandom};
      rs1     = 5'($urandom_range(0, 7));
      rs2     = 5'($urandom_range(0, 7));
      iv      = ($urandom_range(0, 1) != 0);
      iwen    = ($urandom_range(0, 3) != 0);
      ird     = 5'($urandom_range(0, 7));
      flush   = ($urandom_range(0, 29) == 0);
      step("rand");
    end
    rst = 0; idle();

    for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
